reg_write_arbiter: RTL and testbench
====================================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (power of two, at least 2).
REQ-002 SHALL have parameter DW, default 8, register data width.
REQ-003 SHALL have parameter AW, default 2, register address width.
REQ-004 SHALL have parameter MAXBURST, default 4, maximum consecutive write cycles per grant when another requester is waiting.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-007 SHALL have port req  input  NREQ  per-requester write request, held high while the requester has writes pending.
REQ-008 SHALL have port waddr  input  NREQ*AW  packed write addresses; requester i occupies bits [i*AW +: AW].
REQ-009 SHALL have port wdata  input  NREQ*DW  packed write data; requester i occupies bits [i*DW +: DW].
REQ-010 SHALL have port gnt  output  NREQ  registered one-hot grant, or all-zero.
REQ-011 SHALL have port reg_we  output  1  register-bank write enable.
REQ-012 SHALL have port reg_addr  output  AW  register-bank write address.
REQ-013 SHALL have port reg_d  output  DW  register-bank write data (the D inputs of the flip-flop bank).
REQ-014 SHALL have port busy  output  1  high in BUSY state.

Function
REQ-015 SHALL implement two states: IDLE (gnt all-zero) and BUSY (exactly one gnt bit high; that index is the owner).
REQ-016 SHALL drive reg_we = |(gnt & req) combinationally; reg_addr/reg_d SHALL be owner's waddr/wdata slice combinationally, and all-zero when gnt is all-zero.
REQ-017 SHALL define a write as any cycle with gnt[i] & req[i]; requester i SHALL treat that cycle's data as consumed.
REQ-018 SHALL select winners round-robin: first asserted req searching upward, with wrap, from (reference+1) mod NREQ; reference is the current owner in BUSY and last_owner in IDLE.
REQ-019 IDLE with any req high SHALL move to BUSY next cycle, granting the winner, burst_cnt = 0; gnt latency from req rise is exactly one cycle.
REQ-020 BUSY with req[owner] low SHALL release: grant the winner among the other requesters next cycle, else go to IDLE; no write occurs in the release cycle.
REQ-021 BUSY with req[owner] high and burst_cnt < MAXBURST-1 SHALL keep the owner and increment burst_cnt.
REQ-022 BUSY with req[owner] high and burst_cnt == MAXBURST-1 SHALL switch next cycle to the winner among other requesters if any is high (no dead cycle), else keep the owner with burst_cnt = 0.
REQ-023 SHALL update last_owner to the owner on every cycle in BUSY.
REQ-024 SHALL size burst_cnt to hold 0..MAXBURST-1 and never wrap past MAXBURST-1.
REQ-025 Requests arriving in the same cycle as a switch or release SHALL be considered only from the following cycle.
REQ-026 Changes to waddr/wdata of a non-owner SHALL have no effect on outputs.

Reset
REQ-027 On rst high at a rising edge: state IDLE, gnt all-zero, busy 0, burst_cnt 0, last_owner NREQ-1, so requester 0 wins first.
REQ-028 reg_we SHALL be 0 in the cycle after reset regardless of req; rst SHALL override all transitions, including mid-burst.

Verification
REQ-029 Single requester: after reset, req=0100, waddr slice2=1, wdata slice2=0xA5 -> next cycle gnt=0100, reg_we=1, reg_addr=1, reg_d=0xA5; req drops -> gnt=0000, busy=0 one cycle later.
REQ-030 All requesting: req=1111 held from reset -> owners 0,1,2,3,0 in turn, 4 write cycles each, reg_we continuously 1.
REQ-031 Lone long request: req=0001 for 10 cycles -> gnt=0001 throughout, 10 writes, burst_cnt rolls 3->0.
REQ-032 Early release: owner 1; req3 rises; req1 drops after 2 writes -> one cycle with gnt=0010 and reg_we=0, then gnt=1000.
REQ-033 Wrap: with last_owner=3 in IDLE, req=1001 -> gnt=0001 first; after release, gnt=1000.
REQ-034 Reset mid-burst: rst at burst_cnt=2 with req=1111 -> gnt=0000, reg_we=0 next cycle; then gnt=0001.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// reg_write_arbiter
//
// Round-robin arbiter that lets NREQ requesters share one write port of a
// register bank.  A requester that wins the grant may write on every cycle it
// keeps req high.  After MAXBURST consecutive cycles it hands the port to the
// next waiting requester.  When nobody else is waiting, the owner keeps the
// port and its burst count restarts.
//
// Ports
//   clk       in   single clock, rising-edge
//   rst       in   synchronous, active-high reset
//   req       in   [NREQ]     per-requester write request (held while pending)
//   waddr     in   [NREQ*AW]  packed addresses, requester i at [i*AW +: AW]
//   wdata     in   [NREQ*DW]  packed data,      requester i at [i*DW +: DW]
//   gnt       out  [NREQ]     registered one-hot grant (all-zero when idle)
//   reg_we    out             write enable: owner is granted and requesting
//   reg_addr  out  [AW]       owner's address (zero when idle)
//   reg_d     out  [DW]       owner's data    (zero when idle)
//   busy      out             a requester currently owns the port
// -----------------------------------------------------------------------------
module reg_write_arbiter #(
    parameter int NREQ     = 4,
    parameter int DW       = 8,
    parameter int AW       = 2,
    parameter int MAXBURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   waddr,
    input  logic [NREQ*DW-1:0]   wdata,
    output logic [NREQ-1:0]      gnt,
    output logic                 reg_we,
    output logic [AW-1:0]        reg_addr,
    output logic [DW-1:0]        reg_d,
    output logic                 busy
);

    localparam int IW = $clog2(NREQ);
    localparam int BW = (MAXBURST > 1) ? $clog2(MAXBURST) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(MAXBURST - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
    logic [IW-1:0]   last_owner_q, last_owner_d;

    // Round-robin search: first set bit of r looking upward from ref_idx+1,
    // wrapping.  NREQ is a power of two, so the IW-bit add wraps for free and
    // the final iteration (k == NREQ) lands back on ref_idx itself.
    // Result is {found, index}.
    function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [IW-1:0]   ref_idx);
        logic          found;
        logic [IW-1:0] idx;
        logic [IW-1:0] cand;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = ref_idx + IW'(k);
            if (!found && r[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    logic [IW:0]     pick_idle;
    logic [IW:0]     pick_other;
    logic [NREQ-1:0] req_others;

    // gnt_q is one-hot on the owner, so masking with it removes only the owner.
    assign req_others = req & ~gnt_q;
    assign pick_idle  = rr_pick(req, last_owner_q);
    assign pick_other = rr_pick(req_others, owner_q);

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        owner_d      = owner_q;
        burst_cnt_d  = burst_cnt_q;
        last_owner_d = last_owner_q;

        unique case (state_q)
            IDLE: begin
                if (pick_idle[IW]) begin
                    state_d                = BUSY;
                    gnt_d                  = '0;
                    gnt_d[pick_idle[IW-1:0]] = 1'b1;
                    owner_d                = pick_idle[IW-1:0];
                    burst_cnt_d            = '0;
                end
            end

            BUSY: begin
                last_owner_d = owner_q;
                if (!req[owner_q]) begin
                    // Owner let go: hand over directly or fall back to idle.
                    burst_cnt_d = '0;
                    if (pick_other[IW]) begin
                        gnt_d                     = '0;
                        gnt_d[pick_other[IW-1:0]] = 1'b1;
                        owner_d                   = pick_other[IW-1:0];
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (burst_cnt_q != BURST_LAST) begin
                    burst_cnt_d = burst_cnt_q + BW'(1);
                end else begin
                    // Burst exhausted: switch only if someone else is waiting,
                    // otherwise the owner keeps going with a fresh count.
                    burst_cnt_d = '0;
                    if (pick_other[IW]) begin
                        gnt_d                     = '0;
                        gnt_d[pick_other[IW-1:0]] = 1'b1;
                        owner_d                   = pick_other[IW-1:0];
                    end
                end
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            owner_q      <= '0;
            burst_cnt_q  <= '0;
            last_owner_q <= IW'(NREQ - 1);
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            owner_q      <= owner_d;
            burst_cnt_q  <= burst_cnt_d;
            last_owner_q <= last_owner_d;
        end
    end

    // Write port mux: AND-OR over the one-hot grant gives zero when idle and
    // ignores every non-owner slice.
    always_comb begin
        reg_addr = '0;
        reg_d    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) begin
                reg_addr = waddr[i*AW +: AW];
                reg_d    = wdata[i*DW +: DW];
            end
        end
    end

    assign gnt    = gnt_q;
    assign reg_we = |(gnt_q & req);
    assign busy   = (state_q == BUSY);

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;

    localparam int NREQ     = 4;
    localparam int DW       = 8;
    localparam int AW       = 2;
    localparam int MAXBURST = 4;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*AW-1:0]   waddr;
    logic [NREQ*DW-1:0]   wdata;
    logic [NREQ-1:0]      gnt;
    logic                 reg_we;
    logic [AW-1:0]        reg_addr;
    logic [DW-1:0]        reg_d;
    logic                 busy;

    int vectors     = 0;
    int miscompares = 0;

    reg_write_arbiter #(
        .NREQ(NREQ), .DW(DW), .AW(AW), .MAXBURST(MAXBURST)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .waddr(waddr), .wdata(wdata),
        .gnt(gnt), .reg_we(reg_we), .reg_addr(reg_addr), .reg_d(reg_d),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers (stimulus only) ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [NREQ-1:0] r);
        rst = 1'b1;
        req = r;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic set_slice(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        waddr[i*AW +: AW] = a;
        wdata[i*DW +: DW] = d;
    endtask

    // ---------------- reference model ----------------
    // Owner as an integer (-1 = nobody), burst position and last owner,
    // stepped from the arbitration rules with plain integer arithmetic.
    int m_owner, m_burst, m_last;

    function automatic int rr(input logic [NREQ-1:0] mask, input int ref_i);
        for (int k = 1; k <= NREQ; k++) begin
            if (mask[(ref_i + k) % NREQ]) return (ref_i + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_burst = 0;
        m_last  = NREQ - 1;
    endtask

    task automatic model_step(input logic [NREQ-1:0] r, input logic rs);
        int w;
        logic [NREQ-1:0] others;
        if (rs) begin
            model_reset();
        end else if (m_owner < 0) begin
            w = rr(r, m_last);
            if (w >= 0) begin
                m_owner = w;
                m_burst = 0;
            end
        end else begin
            m_last = m_owner;
            others = r;
            others[m_owner] = 1'b0;
            if (!r[m_owner]) begin
                m_owner = rr(others, m_owner);
                m_burst = 0;
            end else if (m_burst < MAXBURST - 1) begin
                m_burst++;
            end else begin
                w = rr(others, m_owner);
                if (w >= 0) m_owner = w;
                m_burst = 0;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        waddr = $urandom;
        wdata = $urandom;
        do_reset('0);
        sample();
        vectors++;
        if ({gnt, reg_we, busy, reg_addr, reg_d} !== '0) begin
            miscompares++;
            $display("FAIL reset_idle: gnt=%b we=%b busy=%b addr=%h d=%h, expected all zero",
                     gnt, reg_we, busy, reg_addr, reg_d);
        end
        // Requests held high across the reset edge must not produce a write.
        req = '1;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        sample();
        vectors++;
        if (gnt !== 4'b0000 || reg_we !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_with_req: gnt=%b we=%b busy=%b, expected 0000 0 0",
                     gnt, reg_we, busy);
        end
        req = '0;
        next_cycle();
    endtask

    task automatic test_single();
        waddr = $urandom;
        wdata = $urandom;
        set_slice(2, 2'd1, 8'hA5);
        do_reset('0);
        req = 4'b0100;
        sample();
        vectors++;
        if (gnt !== 4'b0000) begin
            miscompares++;
            $display("FAIL single_latency: gnt=%b, expected 0000", gnt);
        end
        next_cycle();
        sample();
        vectors++;
        if (gnt !== 4'b0100 || reg_we !== 1'b1 || reg_addr !== 2'd1 ||
            reg_d !== 8'hA5 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_grant: gnt=%b we=%b addr=%h d=%h busy=%b, expected 0100 1 1 a5 1",
                     gnt, reg_we, reg_addr, reg_d, busy);
        end
        // Non-owner slices change: outputs must not follow.
        set_slice(0, 2'd3, 8'h3C);
        set_slice(3, 2'd2, 8'hC3);
        #1;
        vectors++;
        if (reg_addr !== 2'd1 || reg_d !== 8'hA5) begin
            miscompares++;
            $display("FAIL non_owner_data: addr=%h d=%h, expected 1 a5", reg_addr, reg_d);
        end
        next_cycle();
        req = 4'b0000;
        sample();
        vectors++;
        if (gnt !== 4'b0100 || reg_we !== 1'b0) begin
            miscompares++;
            $display("FAIL single_release: gnt=%b we=%b, expected 0100 0", gnt, reg_we);
        end
        next_cycle();
        sample();
        vectors++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_idle: gnt=%b busy=%b, expected 0000 0", gnt, busy);
        end
        next_cycle();
    endtask

    task automatic test_all_requesting();
        logic [NREQ-1:0] exp_gnt;
        int own;
        for (int i = 0; i < NREQ; i++) set_slice(i, AW'(i), DW'(8'h10 + i));
        do_reset('1);
        sample();
        vectors++;
        if (gnt !== 4'b0000 || reg_we !== 1'b0) begin
            miscompares++;
            $display("FAIL all_first_idle: gnt=%b we=%b, expected 0000 0", gnt, reg_we);
        end
        for (int c = 0; c < 5 * MAXBURST; c++) begin
            next_cycle();
            sample();
            own = (c / MAXBURST) % NREQ;
            exp_gnt = '0;
            exp_gnt[own] = 1'b1;
            vectors++;
            if (gnt !== exp_gnt || reg_we !== 1'b1 || reg_addr !== AW'(own) ||
                reg_d !== DW'(8'h10 + own)) begin
                miscompares++;
                $display("FAIL all_rr cycle %0d: gnt=%b we=%b addr=%h d=%h, expected %b 1 %h %h",
                         c, gnt, reg_we, reg_addr, reg_d, exp_gnt, AW'(own), DW'(8'h10 + own));
            end
        end
        req = '0;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_lone_long();
        int writes;
        writes = 0;
        do_reset('0);
        req = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            sample();
            vectors++;
            if (gnt !== 4'b0001) begin
                miscompares++;
                $display("FAIL lone_gnt cycle %0d: gnt=%b, expected 0001", c, gnt);
            end
            if (reg_we === 1'b1) writes++;
        end
        vectors++;
        if (writes !== 10) begin
            miscompares++;
            $display("FAIL lone_writes: writes=%0d, expected 10", writes);
        end
        req = '0;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_early_release();
        do_reset('0);
        req = 4'b0010;
        next_cycle();
        req = 4'b1010;
        sample();
        vectors++;
        if (gnt !== 4'b0010 || reg_we !== 1'b1) begin
            miscompares++;
            $display("FAIL early_write1: gnt=%b we=%b, expected 0010 1", gnt, reg_we);
        end
        next_cycle();
        sample();
        vectors++;
        if (gnt !== 4'b0010 || reg_we !== 1'b1) begin
            miscompares++;
            $display("FAIL early_write2: gnt=%b we=%b, expected 0010 1", gnt, reg_we);
        end
        next_cycle();
        req = 4'b1000;
        sample();
        vectors++;
        if (gnt !== 4'b0010 || reg_we !== 1'b0) begin
            miscompares++;
            $display("FAIL early_release: gnt=%b we=%b, expected 0010 0", gnt, reg_we);
        end
        next_cycle();
        sample();
        vectors++;
        if (gnt !== 4'b1000 || reg_we !== 1'b1) begin
            miscompares++;
            $display("FAIL early_handover: gnt=%b we=%b, expected 1000 1", gnt, reg_we);
        end
        req = '0;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_wrap();
        do_reset('0);
        req = 4'b1001;
        next_cycle();
        sample();
        vectors++;
        if (gnt !== 4'b0001) begin
            miscompares++;
            $display("FAIL wrap_first: gnt=%b, expected 0001", gnt);
        end
        req = 4'b1000;
        #1;
        vectors++;
        if (gnt !== 4'b0001 || reg_we !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_release: gnt=%b we=%b, expected 0001 0", gnt, reg_we);
        end
        next_cycle();
        sample();
        vectors++;
        if (gnt !== 4'b1000 || reg_we !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_second: gnt=%b we=%b, expected 1000 1", gnt, reg_we);
        end
        req = '0;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_reset_mid_burst();
        do_reset('0);
        req = 4'b1111;
        for (int c = 0; c < 3; c++) next_cycle();
        sample();
        vectors++;
        if (gnt !== 4'b0001 || reg_we !== 1'b1) begin
            miscompares++;
            $display("FAIL midburst_pre: gnt=%b we=%b, expected 0001 1", gnt, reg_we);
        end
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        sample();
        vectors++;
        if (gnt !== 4'b0000 || reg_we !== 1'b0) begin
            miscompares++;
            $display("FAIL midburst_reset: gnt=%b we=%b, expected 0000 0", gnt, reg_we);
        end
        next_cycle();
        sample();
        vectors++;
        if (gnt !== 4'b0001 || reg_we !== 1'b1) begin
            miscompares++;
            $display("FAIL midburst_restart: gnt=%b we=%b, expected 0001 1", gnt, reg_we);
        end
        req = '0;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_random();
        logic [NREQ-1:0] exp_gnt;
        logic            exp_we;
        logic [AW-1:0]   exp_addr;
        logic [DW-1:0]   exp_d;
        do_reset('0);
        model_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(3) == 0) req[i] = ~req[i];
            end
            waddr = $urandom;
            wdata = $urandom;
            rst   = ($urandom_range(63) == 0);
            sample();
            exp_gnt  = '0;
            exp_we   = 1'b0;
            exp_addr = '0;
            exp_d    = '0;
            if (m_owner >= 0) begin
                exp_gnt[m_owner] = 1'b1;
                exp_we   = req[m_owner];
                exp_addr = waddr[m_owner*AW +: AW];
                exp_d    = wdata[m_owner*DW +: DW];
            end
            vectors++;
            if (gnt !== exp_gnt || reg_we !== exp_we || reg_addr !== exp_addr ||
                reg_d !== exp_d || busy !== (m_owner >= 0)) begin
                miscompares++;
                $display("FAIL random cycle %0d: gnt=%b we=%b addr=%h d=%h busy=%b, expected %b %b %h %h %b",
                         c, gnt, reg_we, reg_addr, reg_d, busy,
                         exp_gnt, exp_we, exp_addr, exp_d, (m_owner >= 0));
            end
            model_step(req, rst);
            next_cycle();
        end
        rst = 1'b0;
        req = '0;
        next_cycle();
    endtask

    initial begin
        rst   = 1'b1;
        req   = '0;
        waddr = '0;
        wdata = '0;
        test_reset();
        test_single();
        test_all_requesting();
        test_lone_long();
        test_early_release();
        test_wrap();
        test_reset_mid_burst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached, expected completion");
        $fatal(1, "time limit");
    end

endmodule
